// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue/write-back sequencer.
// Holds the opcode values, the instruction field bit positions and
// the sequencer state encoding. The top and the register file both
// import this package.
package alu_sequencer_pkg;

   localparam int NUM_REGS = 4;
   localparam int IMM_W    = 6;
   localparam int DATA_W   = 16;

   // Opcode values, matching the shared ALU opcode table.
   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_SHIFT = 4'd4;
   localparam logic [3:0] OP_LOAD  = 4'd5;
   localparam logic [3:0] OP_STORE = 4'd6;
   localparam logic [3:0] OP_MOVE  = 4'd7;
   localparam logic [3:0] OP_JUMP  = 4'd8;
   localparam logic [3:0] OP_LOADC = 4'd9;

   // Instruction field bit positions.
   localparam int OPC_HI   = 15;
   localparam int OPC_LO   = 12;
   localparam int RD_HI    = 11;
   localparam int RD_LO    = 10;
   localparam int RS_HI    = 9;
   localparam int RS_LO    = 8;
   localparam int IMM_SEL  = 7;
   localparam int SHFT_DIR = 6;
   localparam int IMM_HI   = 5;
   localparam int IMM_LO   = 0;

   // Sequencer states: wait for an instruction, let the ALU settle,
   // then write back (or report a trap).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } seqState_t;

   // True for opcodes this sequencer executes on the ALU itself.
   // Memory, control-flow and undefined opcodes are handed back as traps.
   function automatic logic isAluOp(input logic [3:0] opcode);
      logic result;
      result = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHIFT, OP_MOVE: result = 1'b1;
         OP_LOAD, OP_STORE, OP_JUMP, OP_LOADC:             result = 1'b0;
         default:                                          result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Four-entry, 16-bit register file owned by the ALU sequencer.
// Two registered read ports capture operands on accept, one synchronous
// write port takes the ALU result in write-back, and a combinational
// debug port lets the outside world observe any register.
module alu_regfile
   import alu_sequencer_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              rdEn,
   input  logic [1:0]        rdAddrA,
   input  logic [1:0]        rdAddrB,
   output logic [DATA_W-1:0] rdDataA,
   output logic [DATA_W-1:0] rdDataB,
   input  logic              wrEn,
   input  logic [1:0]        wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic [1:0]        dbgSel,
   output logic [DATA_W-1:0] dbgData
);

   logic [DATA_W-1:0] regFile [NUM_REGS];

   // Storage: everything clears on reset, and the single write port
   // updates the addressed entry during write-back only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regFile[i] <= '0;
         end
      end else if (wrEn) begin
         regFile[wrAddr] <= wrData;
      end
   end

   // Operand capture: both read ports are sampled together on accept so
   // the operands are the pre-write values even when rd equals rs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdDataA <= '0;
         rdDataB <= '0;
      end else if (rdEn) begin
         rdDataA <= regFile[rdAddrA];
         rdDataB <= regFile[rdAddrB];
      end
   end

   assign dbgData = regFile[dbgSel];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/write-back controller sitting in front of the combinational
// 16-bit ALU. Accepts one instruction at a time, presents opcode and
// operands to the ALU from registers, writes the ALU result back into
// the local register file, and traps on anything it does not execute.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [15:0]       i_instr,
   input  logic              i_instr_valid,
   output logic              o_instr_ready,
   output logic [3:0]        o_alu_opcode,
   output logic              o_alu_shift_dir,
   output logic [DATA_W-1:0] o_alu_data1,
   output logic [DATA_W-1:0] o_alu_data2,
   input  logic [DATA_W-1:0] i_alu_result,
   output logic              o_done,
   output logic              o_trap,
   output logic              o_zero,
   input  logic [1:0]        i_dbg_sel,
   output logic [DATA_W-1:0] o_dbg_data
);

   seqState_t         state;
   seqState_t         nextState;
   logic [15:0]       instrReg;
   logic              trapFlag;
   logic              accept;
   logic              regWrEn;
   logic [DATA_W-1:0] operandA;
   logic [DATA_W-1:0] operandB;
   logic [DATA_W-1:0] op2;

   assign o_instr_ready = (state == IDLE) && !i_rst;
   assign accept        = i_instr_valid && o_instr_ready;
   assign regWrEn       = (state == WB) && !trapFlag;

   // State register: reset always returns to IDLE, which also aborts
   // any instruction that was in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: ALU instructions spend one cycle in EXEC so the
   // ALU can settle, traps skip straight to WB to report themselves.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (accept) begin
               nextState = isAluOp(i_instr[OPC_HI:OPC_LO]) ? EXEC : WB;
            end
         end
         EXEC:    nextState = WB;
         WB:      nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Instruction latch: the accepted word is held for the whole
   // instruction and keeps driving the ALU afterwards while idle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         instrReg <= '0;
         trapFlag <= 1'b0;
      end else if (accept) begin
         instrReg <= i_instr;
         trapFlag <= !isAluOp(i_instr[OPC_HI:OPC_LO]);
      end
   end

   // Completion flags: done and trap are single-cycle pulses raised as
   // WB is left; zero only tracks results that were actually written.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_done <= 1'b0;
         o_trap <= 1'b0;
         o_zero <= 1'b0;
      end else begin
         o_done <= (state == WB);
         o_trap <= (state == WB) && trapFlag;
         if (regWrEn) begin
            o_zero <= (i_alu_result == '0);
         end
      end
   end

   alu_regfile u_regfile (
      .clock   (i_clk),
      .reset   (i_rst),
      .rdEn    (accept),
      .rdAddrA (i_instr[RD_HI:RD_LO]),
      .rdAddrB (i_instr[RS_HI:RS_LO]),
      .rdDataA (operandA),
      .rdDataB (operandB),
      .wrEn    (regWrEn),
      .wrAddr  (instrReg[RD_HI:RD_LO]),
      .wrData  (i_alu_result),
      .dbgSel  (i_dbg_sel),
      .dbgData (o_dbg_data)
   );

   assign o_alu_opcode    = instrReg[OPC_HI:OPC_LO];
   assign o_alu_shift_dir = instrReg[SHFT_DIR];

   // Operand steering: everything here comes from registers, so the ALU
   // inputs are stable for the whole EXEC cycle and hold while idle.
   // MOVE passes its source through operand 1 with a zero operand 2.
   always_comb begin
      op2         = instrReg[IMM_SEL] ?
                    {{(DATA_W-IMM_W){1'b0}}, instrReg[IMM_HI:IMM_LO]} : operandB;
      o_alu_data1 = operandA;
      o_alu_data2 = op2;
      if (instrReg[OPC_HI:OPC_LO] == OP_MOVE) begin
         o_alu_data1 = op2;
         o_alu_data2 = '0;
      end
   end

endmodule
